apb_rr_arbiter: RTL and testbench
=================================

// Module: apb_rr_arbiter
// PURPOSE
//   Shares one APB bus between NUM_REQ requesters using round-robin arbitration.
//   Captures one requester's command per transfer and runs the APB SETUP/ACCESS protocol itself.
//   Returns read data and error status to the requester that issued the command, tagged by ID.
//   Adds a PREADY timeout, so a hung slave cannot stall the bus indefinitely.
//   Sits between on-chip initiators and the two APB slave regions (decoded on PADDR[31]).
// PARAMETERS
//   NUM_REQ  4   number of requesters (2..8)
//   ADDR_W   32  address width; PADDR[ADDR_W-1] selects the slave
//   DATA_W   32  data width
//   TIMEOUT  16  max ACCESS cycles without PREADY before abort; 0 disables the timeout
// PORTS
//   PCLK       in   1               APB clock
//   PRESETn    in   1               async active-low reset
//   req_valid  in   NUM_REQ         per-requester command pending; held until req_ready
//   req_write  in   NUM_REQ         1=write 0=read, per requester
//   req_addr   in   NUM_REQ*ADDR_W  packed addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_wdata  in   NUM_REQ*DATA_W  packed write data, same packing as req_addr
//   req_ready  out  NUM_REQ         one-hot accept strobe, combinational, 1 cycle
//   rsp_valid  out  1               completion pulse, 1 cycle
//   rsp_id     out  clog2(NUM_REQ)  index of the requester that completed
//   rsp_rdata  out  DATA_W          PRDATA on read; 0 on write or timeout
//   rsp_err    out  1               PSLVERR at completion, or timeout
//   PSELx      out  2               [0]=PADDR MSB 0, [1]=PADDR MSB 1
//   PENABLE    out  1               APB enable
//   PWRITE     out  1               APB direction
//   PADDR      out  ADDR_W          APB address
//   PWDATA     out  DATA_W          APB write data; 0 on reads
//   PREADY     in   1               slave ready
//   PRDATA     in   DATA_W          slave read data
//   PSLVERR    in   1               slave error, sampled only with PREADY in ACCESS
// BEHAVIOUR
//   Reset (async, PRESETn=0):
//   - all outputs 0; state IDLE; rr pointer 0 (requester 0 has top priority); timeout counter 0.
//   State machine IDLE -> SETUP -> ACCESS:
//   - Arbitration point: state IDLE, or state ACCESS in its completion cycle.
//   - Grant = first i with req_valid[i]=1, searching from ptr upward with wrap.
//   - At the arbitration point, req_ready[grant]=1. On that edge: capture write/addr/wdata, go to SETUP,
//     set ptr=(grant+1)%NUM_REQ.
//   - If no req_valid at the arbitration point, go to or stay in IDLE.
//   - SETUP (1 cycle): PSELx decoded from captured addr; PENABLE=0; PADDR/PWRITE/PWDATA from the
//     captured command. Always proceeds to ACCESS.
//   - ACCESS: PENABLE=1; PSELx/PADDR/PWRITE/PWDATA held stable.
//     Completes on PREADY=1, or when the counter reaches TIMEOUT (TIMEOUT!=0).
//   - Back-to-back: the completion cycle can grant the next command, so the next cycle is SETUP
//     (2 cycles/transfer minimum).
//   - All APB outputs are 0 in IDLE. PSEL is not deasserted between back-to-back transfers to the same slave.
//   Response:
//   - rsp_valid is registered and asserts the cycle after completion.
//   - rsp_id = captured grant; rsp_err = PSLVERR, or 1 on timeout; rsp_rdata = PRDATA if read and no timeout, else 0.
//   - rsp_* hold their values until the next rsp_valid pulse.
//   Timeout:
//   - Counter clears on entry to ACCESS and increments each ACCESS cycle with PREADY=0.
//   - Aborts when count==TIMEOUT-1 and PREADY=0. PREADY and timeout in the same cycle -> PREADY wins (normal completion).
//   Boundaries:
//   - A single requester is granted every transfer.
//   - req_valid dropped before req_ready is ignored; requesters must not do this.
//   - Commands are captured only at grant; later changes on req_* have no effect on the current transfer.
//   - Reset mid-transfer aborts immediately, with no rsp_valid.
// TESTING
//   1 Reset: PRESETn=0 during active ACCESS -> all outputs 0 same cycle; after release, IDLE with ptr=0.
//   2 Req2 write 0x0000_0010/0xDEAD_BEEF, PREADY=1 -> req_ready=0100, SETUP PSELx=01 PENABLE=0,
//     ACCESS PENABLE=1; next cycle rsp_valid=1, rsp_id=2, rsp_err=0.
//   3 All 4 req_valid held high, PREADY=1 -> grants 0,1,2,3,0; a new SETUP every 2 cycles; no IDLE gaps.
//   4 Read 0x8000_0004, PREADY low 3 cycles then high with PRDATA=0x1234_5678, PSLVERR=1
//     -> PSELx=10, PENABLE high 4 cycles; rsp_rdata=0x1234_5678, rsp_err=1.
//   5 TIMEOUT=16, PREADY stuck 0 -> abort after 16 ACCESS cycles; rsp_err=1, rsp_rdata=0; bus back to IDLE.
//   6 Req1 active, req0 asserts mid-transfer -> req0 granted next (ptr=2 wraps to 0), req1 not regranted first.

Source files
------------

// File: rtl/apb_rr_arbiter_if.sv
// Bundle of signals between apb_rr_arbiter and its environment.
//   Requester side : req_valid/req_write/req_addr/req_wdata in, req_ready out,
//                    rsp_valid/rsp_id/rsp_rdata/rsp_err out.
//   APB side       : PSELx/PENABLE/PWRITE/PADDR/PWDATA out, PREADY/PRDATA/PSLVERR in.
// Modports:
//   master - the arbiter itself (APB master, command consumer).
//   slave  - everything around it (requesters and the APB slave regions).
interface apb_rr_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32
);
    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;

    logic                      rsp_valid;
    logic [ID_W-1:0]           rsp_id;
    logic [DATA_W-1:0]         rsp_rdata;
    logic                      rsp_err;

    logic [1:0]                PSELx;
    logic                      PENABLE;
    logic                      PWRITE;
    logic [ADDR_W-1:0]         PADDR;
    logic [DATA_W-1:0]         PWDATA;
    logic                      PREADY;
    logic [DATA_W-1:0]         PRDATA;
    logic                      PSLVERR;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_id, rsp_rdata, rsp_err,
        output PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        input  PREADY, PRDATA, PSLVERR
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_id, rsp_rdata, rsp_err,
        input  PSELx, PENABLE, PWRITE, PADDR, PWDATA,
        output PREADY, PRDATA, PSLVERR
    );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Round-robin arbiter that shares one APB bus between NUM_REQ requesters.
// One command is captured per transfer and run through APB SETUP/ACCESS; the
// result is returned as a one-cycle rsp_valid pulse tagged with the requester
// index. An ACCESS phase that sees no PREADY for TIMEOUT cycles is aborted
// with rsp_err=1 (TIMEOUT=0 disables this).
// Ports:
//   PCLK    - APB clock
//   PRESETn - asynchronous active-low reset
//   bus     - apb_rr_arbiter_if.master: requester command/response signals
//             and the APB master signals (PSELx[0] for PADDR MSB 0,
//             PSELx[1] for PADDR MSB 1)
module apb_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 16
) (
    input  logic                  PCLK,
    input  logic                  PRESETn,
    apb_rr_arbiter_if.master      bus
);
    localparam int ID_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [ID_W:0]    NUM_REQ_W = (ID_W + 1)'(NUM_REQ);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t              state_reg, state_next;
    logic [ID_W-1:0]     ptr_reg;
    logic [ID_W-1:0]     cmd_id_reg;
    logic                cmd_write_reg;
    logic [ADDR_W-1:0]   cmd_addr_reg;
    logic [DATA_W-1:0]   cmd_wdata_reg;
    logic [CNT_W-1:0]    tmo_cnt_reg;
    logic                rsp_valid_reg;
    logic [ID_W-1:0]     rsp_id_reg;
    logic [DATA_W-1:0]   rsp_rdata_reg;
    logic                rsp_err_reg;

    // ------------------------------------------------------------------
    // Round-robin grant: rotate req_valid so ptr_reg lands on bit 0, pick
    // the lowest set bit, then rotate the index back.
    // ------------------------------------------------------------------
    logic [2*NUM_REQ-1:0] rot_wide;
    logic [ID_W-1:0]      first_hit;
    logic                 any_req;
    logic [ID_W:0]        grant_sum;
    logic [ID_W-1:0]      grant_idx;
    logic [ID_W:0]        ptr_sum;
    logic [ID_W-1:0]      ptr_next;

    assign rot_wide = {bus.req_valid, bus.req_valid} >> ptr_reg;
    assign any_req  = |bus.req_valid;

    always_comb begin
        first_hit = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (rot_wide[k]) begin
                first_hit = ID_W'(k);
            end
        end
    end

    assign grant_sum = {1'b0, ptr_reg} + {1'b0, first_hit};
    assign grant_idx = (grant_sum >= NUM_REQ_W) ? ID_W'(grant_sum - NUM_REQ_W)
                                                : ID_W'(grant_sum);
    assign ptr_sum   = {1'b0, grant_idx} + (ID_W + 1)'(1);
    assign ptr_next  = (ptr_sum >= NUM_REQ_W) ? '0 : ID_W'(ptr_sum);

    // ------------------------------------------------------------------
    // Completion and arbitration point
    // ------------------------------------------------------------------
    logic in_access;
    logic tmo_hit;
    logic xfer_done;
    logic arb_point;
    logic grant_fire;

    assign in_access  = (state_reg == ST_ACCESS);
    assign tmo_hit    = (TIMEOUT != 0) && (tmo_cnt_reg == TMO_LAST);
    // PREADY wins over a timeout landing in the same cycle.
    assign xfer_done  = in_access && (bus.PREADY || tmo_hit);
    assign arb_point  = (state_reg == ST_IDLE) || xfer_done;
    assign grant_fire = arb_point && any_req;

    // Reset also masks the combinational accept strobe so every output is
    // quiet while PRESETn is low.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = PRESETn && grant_fire && (grant_idx == ID_W'(gi));
        end
    endgenerate

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:   state_next = any_req ? ST_SETUP : ST_IDLE;
            ST_SETUP:  state_next = ST_ACCESS;
            ST_ACCESS: begin
                if (xfer_done) begin
                    state_next = any_req ? ST_SETUP : ST_IDLE;
                end
            end
            default:   state_next = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Command capture, rr pointer and timeout counter
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ptr_reg       <= '0;
            cmd_id_reg    <= '0;
            cmd_write_reg <= 1'b0;
            cmd_addr_reg  <= '0;
            cmd_wdata_reg <= '0;
            tmo_cnt_reg   <= '0;
        end else begin
            if (grant_fire) begin
                ptr_reg       <= ptr_next;
                cmd_id_reg    <= grant_idx;
                cmd_write_reg <= bus.req_write[grant_idx];
                cmd_addr_reg  <= bus.req_addr[grant_idx*ADDR_W +: ADDR_W];
                cmd_wdata_reg <= bus.req_wdata[grant_idx*DATA_W +: DATA_W];
            end
            if (state_reg == ST_SETUP) begin
                tmo_cnt_reg <= '0;
            end else if (in_access && !bus.PREADY) begin
                tmo_cnt_reg <= tmo_cnt_reg + CNT_W'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Response: pulse the cycle after completion, payload held until the
    // next pulse.
    // ------------------------------------------------------------------
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            rsp_valid_reg <= 1'b0;
            rsp_id_reg    <= '0;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            rsp_valid_reg <= xfer_done;
            if (xfer_done) begin
                rsp_id_reg    <= cmd_id_reg;
                // Without PREADY the completion is a timeout: PSLVERR is not
                // valid then, and no read data is returned.
                rsp_err_reg   <= bus.PREADY ? bus.PSLVERR : 1'b1;
                rsp_rdata_reg <= (bus.PREADY && !cmd_write_reg) ? bus.PRDATA : '0;
            end
        end
    end

    assign bus.rsp_valid = rsp_valid_reg;
    assign bus.rsp_id    = rsp_id_reg;
    assign bus.rsp_rdata = rsp_rdata_reg;
    assign bus.rsp_err   = rsp_err_reg;

    // ------------------------------------------------------------------
    // APB outputs: all zero in IDLE, otherwise driven from the captured
    // command. ACCESS -> SETUP back-to-back keeps PSEL up when the slave
    // region does not change.
    // ------------------------------------------------------------------
    always_comb begin
        bus.PSELx   = 2'b00;
        bus.PENABLE = 1'b0;
        bus.PWRITE  = 1'b0;
        bus.PADDR   = '0;
        bus.PWDATA  = '0;
        if (state_reg != ST_IDLE) begin
            bus.PSELx   = cmd_addr_reg[ADDR_W-1] ? 2'b10 : 2'b01;
            bus.PENABLE = in_access;
            bus.PWRITE  = cmd_write_reg;
            bus.PADDR   = cmd_addr_reg;
            bus.PWDATA  = cmd_write_reg ? cmd_wdata_reg : '0;
        end
    end
endmodule

// File: tb/tb_apb_rr_arbiter.sv
module tb_apb_rr_arbiter;
    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 32;
    localparam int DATA_W  = 32;
    localparam int TIMEOUT = 16;

    logic PCLK;
    logic PRESETn;
    int   n_cmp;
    int   n_err;

    apb_rr_arbiter_if #(.NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    apb_rr_arbiter #(
        .NUM_REQ(NUM_REQ), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT(TIMEOUT)
    ) dut (
        .PCLK   (PCLK),
        .PRESETn(PRESETn),
        .bus    (bus.master)
    );

    initial PCLK = 1'b0;
    always #5 PCLK = ~PCLK;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, outputs are sampled
    // one unit later, well clear of both clock edges.
    task automatic tick();
        @(posedge PCLK);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic wr, input logic [31:0] addr,
                           input logic [31:0] wdata);
        bus.req_write[i]           = wr;
        bus.req_addr[i*32 +: 32]   = addr;
        bus.req_wdata[i*32 +: 32]  = wdata;
    endtask

    task automatic chk_bus_idle(input string tag);
        chk({tag, "_psel"},    64'(bus.PSELx),   64'd0);
        chk({tag, "_penable"}, 64'(bus.PENABLE), 64'd0);
        chk({tag, "_pwrite"},  64'(bus.PWRITE),  64'd0);
        chk({tag, "_paddr"},   64'(bus.PADDR),   64'd0);
        chk({tag, "_pwdata"},  64'(bus.PWDATA),  64'd0);
    endtask

    initial begin
        int n_en;
        n_cmp = 0;
        n_err = 0;
        PRESETn       = 1'b0;
        bus.req_valid = '0;
        bus.req_write = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.PREADY    = 1'b0;
        bus.PRDATA    = '0;
        bus.PSLVERR   = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        settle();
        chk_bus_idle("rst");
        chk("rst_ready",     64'(bus.req_ready), 64'd0);
        chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("rst_rsp_err",   64'(bus.rsp_err),   64'd0);
        chk("rst_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        PRESETn = 1'b1;
        tick();
        settle();
        chk_bus_idle("idle");

        // ---------------- all four requesting, ptr=0: grants 0,1,2,3,0 ----------------
        for (int i = 0; i < NUM_REQ; i++) set_req(i, 1'b0, 32'h100 + 32'(i) * 32'h10, 32'h0);
        bus.PREADY    = 1'b1;
        bus.PRDATA    = 32'hA5A5_0000;
        bus.req_valid = 4'b1111;
        for (int g = 0; g < 5; g++) begin
            settle();
            chk($sformatf("rr_ready_g%0d", g), 64'(bus.req_ready), 64'(4'b0001 << (g % 4)));
            chk($sformatf("rr_penable_arb_g%0d", g), 64'(bus.PENABLE), 64'(g != 0));
            tick();
            chk($sformatf("rr_setup_penable_g%0d", g), 64'(bus.PENABLE), 64'd0);
            chk($sformatf("rr_setup_psel_g%0d", g), 64'(bus.PSELx), 64'd1);
            chk($sformatf("rr_setup_paddr_g%0d", g), 64'(bus.PADDR), 64'(32'h100 + 32'((g % 4) * 16)));
            if (g != 0) begin
                chk($sformatf("rr_rsp_valid_g%0d", g), 64'(bus.rsp_valid), 64'd1);
                chk($sformatf("rr_rsp_id_g%0d", g), 64'(bus.rsp_id), 64'((g - 1) % 4));
            end
            if (g == 4) bus.req_valid = '0;
            tick();
        end
        chk("rr_last_ready", 64'(bus.req_ready), 64'd0);
        tick();
        chk("rr_end_psel",      64'(bus.PSELx),     64'd0);
        chk("rr_end_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("rr_end_rsp_id",    64'(bus.rsp_id),    64'd0);
        chk("rr_end_rsp_rdata", 64'(bus.rsp_rdata), 64'hA5A5_0000);
        chk("rr_end_rsp_err",   64'(bus.rsp_err),   64'd0);

        // ---------------- req2 write, ptr=1 ----------------
        set_req(2, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
        bus.PRDATA    = 32'h5555_5555;
        bus.req_valid = 4'b0100;
        settle();
        chk("wr_ready", 64'(bus.req_ready), 64'b0100);
        tick();
        bus.req_valid = '0;
        settle();
        chk("wr_setup_psel",    64'(bus.PSELx),   64'b01);
        chk("wr_setup_penable", 64'(bus.PENABLE), 64'd0);
        chk("wr_setup_pwrite",  64'(bus.PWRITE),  64'd1);
        chk("wr_setup_paddr",   64'(bus.PADDR),   64'h10);
        chk("wr_setup_pwdata",  64'(bus.PWDATA),  64'hDEAD_BEEF);
        chk("wr_rsp_quiet",     64'(bus.rsp_valid), 64'd0);
        tick();
        chk("wr_access_penable", 64'(bus.PENABLE), 64'd1);
        chk("wr_access_psel",    64'(bus.PSELx),   64'b01);
        chk("wr_access_pwdata",  64'(bus.PWDATA),  64'hDEAD_BEEF);
        tick();
        chk("wr_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        chk("wr_rsp_id",    64'(bus.rsp_id),    64'd2);
        chk("wr_rsp_err",   64'(bus.rsp_err),   64'd0);
        chk("wr_rsp_rdata", 64'(bus.rsp_rdata), 64'd0);
        chk("wr_idle_psel", 64'(bus.PSELx),     64'd0);
        tick();
        chk("wr_rsp_pulse", 64'(bus.rsp_valid), 64'd0);
        chk("wr_rsp_hold",  64'(bus.rsp_id),    64'd2);

        // ---------------- req3 read upper region, 3 wait states, PSLVERR ----------------
        set_req(3, 1'b0, 32'h8000_0004, 32'hFFFF_0000);
        bus.PREADY    = 1'b0;
        bus.req_valid = 4'b1000;
        settle();
        chk("rd_ready", 64'(bus.req_ready), 64'b1000);
        tick();
        bus.req_valid = '0;
        settle();
        chk("rd_setup_psel",   64'(bus.PSELx),  64'b10);
        chk("rd_setup_pwrite", 64'(bus.PWRITE), 64'd0);
        chk("rd_setup_pwdata", 64'(bus.PWDATA), 64'd0);
        tick();
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                bus.PREADY  = 1'b1;
                bus.PRDATA  = 32'h1234_5678;
                bus.PSLVERR = 1'b1;
            end
            settle();
            chk($sformatf("rd_penable_c%0d", c), 64'(bus.PENABLE), 64'd1);
            chk($sformatf("rd_rsp_quiet_c%0d", c), 64'(bus.rsp_valid), 64'd0);
            tick();
        end
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        settle();
        chk("rd_end_penable", 64'(bus.PENABLE),   64'd0);
        chk("rd_rsp_valid",   64'(bus.rsp_valid), 64'd1);
        chk("rd_rsp_id",      64'(bus.rsp_id),    64'd3);
        chk("rd_rsp_rdata",   64'(bus.rsp_rdata), 64'h1234_5678);
        chk("rd_rsp_err",     64'(bus.rsp_err),   64'd1);

        // ---------------- req1 then req0 arrives mid-transfer, ptr=0 ----------------
        set_req(1, 1'b1, 32'h0000_0020, 32'h1111_1111);
        set_req(0, 1'b1, 32'h8000_0030, 32'h2222_2222);
        bus.PREADY    = 1'b1;
        bus.req_valid = 4'b0010;
        settle();
        chk("wrap_ready1", 64'(bus.req_ready), 64'b0010);
        tick();
        bus.req_valid = 4'b0011;
        settle();
        chk("wrap_setup1_paddr", 64'(bus.PADDR), 64'h20);
        tick();
        chk("wrap_ready0", 64'(bus.req_ready), 64'b0001);
        tick();
        bus.req_valid = 4'b0010;
        settle();
        chk("wrap_setup0_paddr", 64'(bus.PADDR),     64'h8000_0030);
        chk("wrap_setup0_psel",  64'(bus.PSELx),     64'b10);
        chk("wrap_rsp_id1",      64'(bus.rsp_id),    64'd1);
        chk("wrap_rsp_valid1",   64'(bus.rsp_valid), 64'd1);
        tick();
        chk("wrap_ready1_again", 64'(bus.req_ready), 64'b0010);
        tick();
        bus.req_valid = '0;
        settle();
        chk("wrap_setup1b_psel", 64'(bus.PSELx),  64'b01);
        chk("wrap_rsp_id0",      64'(bus.rsp_id), 64'd0);
        tick();
        chk("wrap_last_ready", 64'(bus.req_ready), 64'd0);
        tick();
        chk("wrap_rsp_id1b", 64'(bus.rsp_id),   64'd1);
        chk("wrap_idle",     64'(bus.PENABLE),  64'd0);

        // ---------------- timeout, ptr=2 ----------------
        set_req(2, 1'b0, 32'h0000_0040, 32'h0);
        bus.PREADY    = 1'b0;
        bus.PRDATA    = 32'hFFFF_FFFF;
        bus.req_valid = 4'b0100;
        settle();
        chk("tmo_ready", 64'(bus.req_ready), 64'b0100);
        tick();
        bus.req_valid = '0;
        tick();
        n_en = 0;
        while (bus.PENABLE === 1'b1 && n_en < 40) begin
            n_en++;
            tick();
        end
        chk("tmo_access_cycles", 64'(n_en),          64'd16);
        chk("tmo_rsp_valid",     64'(bus.rsp_valid), 64'd1);
        chk("tmo_rsp_id",        64'(bus.rsp_id),    64'd2);
        chk("tmo_rsp_err",       64'(bus.rsp_err),   64'd1);
        chk("tmo_rsp_rdata",     64'(bus.rsp_rdata), 64'd0);
        chk("tmo_psel",          64'(bus.PSELx),     64'd0);

        // ---------------- reset during ACCESS, ptr=3 ----------------
        set_req(0, 1'b0, 32'h0000_0050, 32'h0);
        bus.req_valid = 4'b0001;
        settle();
        chk("mid_ready", 64'(bus.req_ready), 64'b0001);
        tick();
        bus.req_valid = '0;
        tick();
        tick();
        chk("mid_in_access", 64'(bus.PENABLE), 64'd1);
        PRESETn       = 1'b0;
        bus.req_valid = 4'b1111;
        settle();
        chk_bus_idle("mid_rst");
        chk("mid_rst_ready",     64'(bus.req_ready), 64'd0);
        chk("mid_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        chk("mid_rst_rsp_id",    64'(bus.rsp_id),    64'd0);
        tick();
        bus.PREADY    = 1'b1;
        tick();
        PRESETn       = 1'b1;
        bus.req_valid = 4'b1001;
        settle();
        chk("post_rst_ready",     64'(bus.req_ready), 64'b0001);
        chk("post_rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        tick();
        bus.req_valid = '0;
        settle();
        chk("post_rst_paddr", 64'(bus.PADDR), 64'h50);
        tick();
        tick();
        chk("post_rst_rsp_id", 64'(bus.rsp_id), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
